// File: rtl/rs_branch_pkg.sv
// Shared types for the branch reservation station: issue packet, branch func codes,
// per-entry storage layout and the operand capture helper used by dispatch and wakeup.
package rs_branch_pkg;

    localparam int XLEN            = 32;
    localparam int PRF_LEN         = 6;
    localparam int ROB_LEN         = 5;
    localparam int RS_SIZE_DEFAULT = 4;

    typedef enum logic [2:0] {
        BEQ  = 3'b000,
        BNE  = 3'b001,
        BLT  = 3'b100,
        BGE  = 3'b101,
        BLTU = 3'b110,
        BGEU = 3'b111
    } BR_FUNC;

    typedef struct packed {
        BR_FUNC              func;
        logic [XLEN-1:0]     pc;
        logic [XLEN-1:0]     imm;
        logic [ROB_LEN-1:0]  rob_idx;
        logic [XLEN-1:0]     rs1_val;
        logic [XLEN-1:0]     rs2_val;
    } RS_FU_PACKET;

    typedef struct packed {
        logic [PRF_LEN-1:0]  tag;
        logic                rdy;
        logic [XLEN-1:0]     val;
    } RS_OPERAND;

    typedef struct packed {
        logic                valid;
        BR_FUNC              func;
        logic [XLEN-1:0]     pc;
        logic [XLEN-1:0]     imm;
        logic [ROB_LEN-1:0]  rob_idx;
        RS_OPERAND           rs1;
        RS_OPERAND           rs2;
    } RS_BR_ENTRY;

    // A waiting operand takes the broadcast value when its tag matches; ready ones never change.
    function automatic RS_OPERAND capture_operand(
        input RS_OPERAND          op,
        input logic               cdb_valid,
        input logic [PRF_LEN-1:0] cdb_tag,
        input logic [XLEN-1:0]    cdb_value
    );
        RS_OPERAND res;
        res = op;
        if (!op.rdy && cdb_valid && (op.tag == cdb_tag)) begin
            res.rdy = 1'b1;
            res.val = cdb_value;
        end
        return res;
    endfunction

    function automatic RS_FU_PACKET to_packet(input RS_BR_ENTRY e);
        RS_FU_PACKET p;
        p.func    = e.func;
        p.pc      = e.pc;
        p.imm     = e.imm;
        p.rob_idx = e.rob_idx;
        p.rs1_val = e.rs1.val;
        p.rs2_val = e.rs2.val;
        return p;
    endfunction

endpackage

// File: rtl/rs_branch_if.sv
// Dispatch / CDB / issue bundle for the branch reservation station.
// slave is the station's view, master is the surrounding pipeline's view.
interface rs_branch_if;
    import rs_branch_pkg::*;

    logic                dis_valid;
    logic [2:0]          dis_func;
    logic [XLEN-1:0]     dis_pc;
    logic [XLEN-1:0]     dis_imm;
    logic [ROB_LEN-1:0]  dis_rob_idx;
    logic [PRF_LEN-1:0]  dis_rs1_tag;
    logic [PRF_LEN-1:0]  dis_rs2_tag;
    logic                dis_rs1_rdy;
    logic                dis_rs2_rdy;
    logic [XLEN-1:0]     dis_rs1_val;
    logic [XLEN-1:0]     dis_rs2_val;
    logic                cdb_valid;
    logic [PRF_LEN-1:0]  cdb_tag;
    logic [XLEN-1:0]     cdb_value;
    logic                squash;
    logic                fu_ready;
    logic                rs_full;
    logic                issue_valid;
    RS_FU_PACKET         rs_fu_packet;

    modport master (
        output dis_valid, dis_func, dis_pc, dis_imm, dis_rob_idx,
               dis_rs1_tag, dis_rs2_tag, dis_rs1_rdy, dis_rs2_rdy,
               dis_rs1_val, dis_rs2_val, cdb_valid, cdb_tag, cdb_value,
               squash, fu_ready,
        input  rs_full, issue_valid, rs_fu_packet
    );

    modport slave (
        input  dis_valid, dis_func, dis_pc, dis_imm, dis_rob_idx,
               dis_rs1_tag, dis_rs2_tag, dis_rs1_rdy, dis_rs2_rdy,
               dis_rs1_val, dis_rs2_val, cdb_valid, cdb_tag, cdb_value,
               squash, fu_ready,
        output rs_full, issue_valid, rs_fu_packet
    );
endinterface

// File: rtl/rs_age_select.sv
// Oldest-ready picker: age_matrix[r][c]=1 means entry r is older than entry c.
// An entry wins when it is ready and no ready entry is older than it.
module rs_age_select #(
    parameter int RS_SIZE = 4
) (
    input  logic [RS_SIZE-1:0] age_matrix [RS_SIZE],
    input  logic [RS_SIZE-1:0] ready,
    output logic [RS_SIZE-1:0] grant,
    output logic               any_ready
);

    genvar gi, gj;
    generate
        for (gi = 0; gi < RS_SIZE; gi++) begin : g_grant
            logic [RS_SIZE-1:0] older_col;
            for (gj = 0; gj < RS_SIZE; gj++) begin : g_col
                assign older_col[gj] = age_matrix[gj][gi];
            end
            assign grant[gi] = ready[gi] & ~(|(ready & older_col));
        end
    endgenerate

    assign any_ready = |ready;

endmodule

// File: rtl/rs_branch.sv
// Branch reservation station: buffers dispatched branches, captures operands from the CDB
// and issues the oldest ready entry. Optional perf counters under RS_BRANCH_PERF_CNT_EN.
module rs_branch
    import rs_branch_pkg::*;
#(
    parameter int RS_SIZE = RS_SIZE_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    rs_branch_if.slave  bus
`ifdef RS_BRANCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_full_cnt
`endif
);

    RS_BR_ENTRY          entries    [RS_SIZE];
    logic [RS_SIZE-1:0]  age_matrix [RS_SIZE];
    logic [RS_SIZE-1:0]  valid_vec;
    logic [RS_SIZE-1:0]  ready_vec;
    logic [RS_SIZE-1:0]  free_vec;
    logic [RS_SIZE-1:0]  free_onehot;
    logic [RS_SIZE-1:0]  grant;
    logic                any_ready;
    logic                rs_full;
    logic                do_dispatch;
    logic                do_issue;
    RS_BR_ENTRY          dis_entry;
    RS_FU_PACKET         issue_pkt;
    RS_OPERAND           dis_rs1;
    RS_OPERAND           dis_rs2;

    assign free_vec    = ~valid_vec;
    // Two's-complement trick isolates the lowest free slot.
    assign free_onehot = free_vec & (~free_vec + RS_SIZE'(1));
    assign rs_full     = &valid_vec;
    assign do_dispatch = bus.dis_valid & ~bus.squash & ~rs_full;
    assign do_issue    = any_ready & bus.fu_ready;

    assign dis_rs1 = capture_operand('{tag: bus.dis_rs1_tag, rdy: bus.dis_rs1_rdy, val: bus.dis_rs1_val},
                                     bus.cdb_valid, bus.cdb_tag, bus.cdb_value);
    assign dis_rs2 = capture_operand('{tag: bus.dis_rs2_tag, rdy: bus.dis_rs2_rdy, val: bus.dis_rs2_val},
                                     bus.cdb_valid, bus.cdb_tag, bus.cdb_value);

    always_comb begin
        dis_entry         = '0;
        dis_entry.valid   = 1'b1;
        dis_entry.func    = BR_FUNC'(bus.dis_func);
        dis_entry.pc      = bus.dis_pc;
        dis_entry.imm     = bus.dis_imm;
        dis_entry.rob_idx = bus.dis_rob_idx;
        dis_entry.rs1     = dis_rs1;
        dis_entry.rs2     = dis_rs2;
    end

    genvar gi;
    generate
        for (gi = 0; gi < RS_SIZE; gi++) begin : g_entry
            RS_BR_ENTRY         entry_reg;
            logic [RS_SIZE-1:0] age_row_reg;

            // A new entry clears its own row (older than nothing); every other row marks
            // itself older than it. Bits held by invalid rows are never consulted.
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    entry_reg   <= '0;
                    age_row_reg <= '0;
                end else if (bus.squash) begin
                    entry_reg.valid <= 1'b0;
                    age_row_reg     <= '0;
                end else if (do_dispatch && free_onehot[gi]) begin
                    entry_reg   <= dis_entry;
                    age_row_reg <= '0;
                end else begin
                    if (do_issue && grant[gi]) begin
                        entry_reg.valid <= 1'b0;
                    end
                    entry_reg.rs1 <= capture_operand(entry_reg.rs1, bus.cdb_valid, bus.cdb_tag, bus.cdb_value);
                    entry_reg.rs2 <= capture_operand(entry_reg.rs2, bus.cdb_valid, bus.cdb_tag, bus.cdb_value);
                    if (do_dispatch) begin
                        age_row_reg <= age_row_reg | free_onehot;
                    end
                end
            end

            assign entries[gi]    = entry_reg;
            assign age_matrix[gi] = age_row_reg;
            assign valid_vec[gi]  = entry_reg.valid;
            assign ready_vec[gi]  = entry_reg.valid & entry_reg.rs1.rdy & entry_reg.rs2.rdy;
        end
    endgenerate

    rs_age_select #(
        .RS_SIZE (RS_SIZE)
    ) u_age_select (
        .age_matrix (age_matrix),
        .ready      (ready_vec),
        .grant      (grant),
        .any_ready  (any_ready)
    );

    // Grant is one-hot or zero, so the packet reads as all-zero when nothing is ready.
    always_comb begin
        issue_pkt = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            if (grant[i]) begin
                issue_pkt = to_packet(entries[i]);
            end
        end
    end

    assign bus.issue_valid  = any_ready;
    assign bus.rs_fu_packet = issue_pkt;
    assign bus.rs_full      = rs_full;

`ifdef RS_BRANCH_PERF_CNT_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            perf_stall_cnt <= '0;
            perf_full_cnt  <= '0;
        end else begin
            if (any_ready && !bus.fu_ready) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
            if (rs_full) begin
                perf_full_cnt <= perf_full_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_rs_branch.sv
// Self-checking bench for rs_branch: directed scenarios then random traffic, all compared
// every cycle against an age-ordered queue model of the station.
module tb_rs_branch;
    import rs_branch_pkg::*;

    localparam int N = 4;
    localparam int W = 160;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    rs_branch_if bus ();

`ifdef RS_BRANCH_PERF_CNT_EN
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_full_cnt;
`endif

    rs_branch #(.RS_SIZE(N)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
`ifdef RS_BRANCH_PERF_CNT_EN
        ,
        .perf_stall_cnt (perf_stall_cnt),
        .perf_full_cnt  (perf_full_cnt)
`endif
    );

    // Model: entries kept in dispatch order, oldest at index 0.
    typedef struct {
        logic [2:0]         func;
        logic [XLEN-1:0]    pc;
        logic [XLEN-1:0]    imm;
        logic [ROB_LEN-1:0] rob;
        logic [PRF_LEN-1:0] t1;
        logic               r1;
        logic [XLEN-1:0]    v1;
        logic [PRF_LEN-1:0] t2;
        logic               r2;
        logic [XLEN-1:0]    v2;
    } m_ent_t;

    m_ent_t      mq[$];
    int          errors = 0;
    int          checks = 0;
    int unsigned exp_stall = 0;
    int unsigned exp_full  = 0;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int model_pick();
        for (int i = 0; i < mq.size(); i++) begin
            if (mq[i].r1 && mq[i].r2) return i;
        end
        return -1;
    endfunction

    task automatic set_dis(input logic [2:0] f, input logic [XLEN-1:0] pc, input logic [XLEN-1:0] imm,
                           input logic [ROB_LEN-1:0] rob,
                           input logic [PRF_LEN-1:0] t1, input logic r1, input logic [XLEN-1:0] v1,
                           input logic [PRF_LEN-1:0] t2, input logic r2, input logic [XLEN-1:0] v2);
        bus.dis_valid   = 1'b1;
        bus.dis_func    = f;
        bus.dis_pc      = pc;
        bus.dis_imm     = imm;
        bus.dis_rob_idx = rob;
        bus.dis_rs1_tag = t1;
        bus.dis_rs1_rdy = r1;
        bus.dis_rs1_val = v1;
        bus.dis_rs2_tag = t2;
        bus.dis_rs2_rdy = r2;
        bus.dis_rs2_val = v2;
    endtask

    task automatic set_cdb(input logic [PRF_LEN-1:0] tag, input logic [XLEN-1:0] value);
        bus.cdb_valid = 1'b1;
        bus.cdb_tag   = tag;
        bus.cdb_value = value;
    endtask

    // One clock: check outputs against the model, advance the model at the edge, clear pulses.
    task automatic cycle();
        int          sel;
        logic        full_e;
        RS_FU_PACKET ep;
        m_ent_t      e;
        sel    = model_pick();
        full_e = (mq.size() == N);
        ep     = '0;
        if (sel >= 0) begin
            ep.func    = BR_FUNC'(mq[sel].func);
            ep.pc      = mq[sel].pc;
            ep.imm     = mq[sel].imm;
            ep.rob_idx = mq[sel].rob;
            ep.rs1_val = mq[sel].v1;
            ep.rs2_val = mq[sel].v2;
        end
        check("issue_valid", W'(bus.issue_valid), W'(sel >= 0));
        check("rs_full", W'(bus.rs_full), W'(full_e));
        check("packet", W'(bus.rs_fu_packet), W'(ep));
        @(posedge clock);
        if (sel >= 0 && !bus.fu_ready) exp_stall++;
        if (full_e) exp_full++;
        if (bus.squash) begin
            mq.delete();
        end else begin
            if (sel >= 0 && bus.fu_ready) mq.delete(sel);
            for (int i = 0; i < mq.size(); i++) begin
                e = mq[i];
                if (bus.cdb_valid && !e.r1 && e.t1 == bus.cdb_tag) begin e.r1 = 1'b1; e.v1 = bus.cdb_value; end
                if (bus.cdb_valid && !e.r2 && e.t2 == bus.cdb_tag) begin e.r2 = 1'b1; e.v2 = bus.cdb_value; end
                mq[i] = e;
            end
            if (bus.dis_valid && !full_e) begin
                e.func = bus.dis_func;   e.pc = bus.dis_pc;       e.imm = bus.dis_imm;
                e.rob  = bus.dis_rob_idx;
                e.t1   = bus.dis_rs1_tag; e.r1 = bus.dis_rs1_rdy; e.v1 = bus.dis_rs1_val;
                e.t2   = bus.dis_rs2_tag; e.r2 = bus.dis_rs2_rdy; e.v2 = bus.dis_rs2_val;
                if (bus.cdb_valid && !e.r1 && e.t1 == bus.cdb_tag) begin e.r1 = 1'b1; e.v1 = bus.cdb_value; end
                if (bus.cdb_valid && !e.r2 && e.t2 == bus.cdb_tag) begin e.r2 = 1'b1; e.v2 = bus.cdb_value; end
                mq.push_back(e);
            end
        end
        @(negedge clock);
        bus.dis_valid = 1'b0;
        bus.cdb_valid = 1'b0;
        bus.squash    = 1'b0;
`ifdef RS_BRANCH_PERF_CNT_EN
        check("perf_stall_cnt", W'(perf_stall_cnt), W'(exp_stall));
        check("perf_full_cnt", W'(perf_full_cnt), W'(exp_full));
`endif
    endtask

    initial begin
        logic [2:0] funcs [6];
        funcs = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111};
        bus.dis_valid = 1'b0; bus.dis_func = '0; bus.dis_pc = '0; bus.dis_imm = '0;
        bus.dis_rob_idx = '0; bus.dis_rs1_tag = '0; bus.dis_rs2_tag = '0;
        bus.dis_rs1_rdy = 1'b0; bus.dis_rs2_rdy = 1'b0; bus.dis_rs1_val = '0; bus.dis_rs2_val = '0;
        bus.cdb_valid = 1'b0; bus.cdb_tag = '0; bus.cdb_value = '0;
        bus.squash = 1'b0; bus.fu_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clock);
        check("reset_issue_valid", W'(bus.issue_valid), W'(0));
        check("reset_rs_full", W'(bus.rs_full), W'(0));
        check("reset_packet", W'(bus.rs_fu_packet), W'(0));
        reset = 1'b1;

        // Basic BEQ 5/5 issue
        bus.fu_ready = 1'b1;
        set_dis(3'b000, 32'h100, 32'h20, 5'd3, 6'd1, 1'b1, 32'd5, 6'd2, 1'b1, 32'd5);
        cycle();
        check("beq_issue_valid", W'(bus.issue_valid), W'(1));
        check("beq_func", W'(bus.rs_fu_packet.func), W'(3'b000));
        check("beq_rs1_val", W'(bus.rs_fu_packet.rs1_val), W'(5));
        check("beq_rs2_val", W'(bus.rs_fu_packet.rs2_val), W'(5));
        check("beq_rob", W'(bus.rs_fu_packet.rob_idx), W'(3));
        cycle();
        check("beq_freed", W'(bus.issue_valid), W'(0));

        // A waits on tag 7, younger B is ready and goes first
        set_dis(3'b001, 32'h200, 32'h4, 5'd10, 6'd7, 1'b0, 32'd0, 6'd3, 1'b1, 32'd2);
        cycle();
        set_dis(3'b100, 32'h204, 32'h8, 5'd11, 6'd4, 1'b1, 32'd1, 6'd5, 1'b1, 32'd9);
        cycle();
        check("young_first_rob", W'(bus.rs_fu_packet.rob_idx), W'(11));
        cycle();
        set_cdb(6'd7, 32'h10);
        cycle();
        check("wakeup_valid", W'(bus.issue_valid), W'(1));
        check("wakeup_rs1_val", W'(bus.rs_fu_packet.rs1_val), W'(32'h10));
        check("wakeup_rob", W'(bus.rs_fu_packet.rob_idx), W'(10));
        cycle();

        // Fill with the FU stalled, then drain oldest-first and refill freed slot
        bus.fu_ready = 1'b0;
        for (int i = 0; i < N; i++) begin
            set_dis(3'b101, 32'h300 + 32'(i * 4), 32'h40, 5'(20 + i), 6'd1, 1'b1, 32'(i), 6'd2, 1'b1, 32'(i + 100));
            cycle();
        end
        check("full_rs_full", W'(bus.rs_full), W'(1));
        check("full_oldest_rob", W'(bus.rs_fu_packet.rob_idx), W'(20));
        cycle();
        bus.fu_ready = 1'b1;
        cycle();
        check("full_drop", W'(bus.rs_full), W'(0));
        check("full_next_rob", W'(bus.rs_fu_packet.rob_idx), W'(21));
        set_dis(3'b110, 32'h400, 32'h0, 5'd30, 6'd1, 1'b1, 32'd7, 6'd2, 1'b1, 32'd8);
        repeat (5) cycle();

        // Dispatch-cycle CDB bypass on rs2
        set_dis(3'b111, 32'h500, 32'hC, 5'd5, 6'd1, 1'b1, 32'd3, 6'd9, 1'b0, 32'd0);
        set_cdb(6'd9, 32'hFFFF_FFFF);
        cycle();
        check("bypass_valid", W'(bus.issue_valid), W'(1));
        check("bypass_rs2_val", W'(bus.rs_fu_packet.rs2_val), W'(32'hFFFF_FFFF));
        cycle();

        // Squash with a concurrent dispatch
        bus.fu_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_dis(3'b000, 32'h600, 32'h0, 5'(i), 6'd1, 1'b1, 32'd1, 6'd2, 1'b1, 32'd1);
            cycle();
        end
        set_dis(3'b001, 32'h700, 32'h0, 5'd9, 6'd1, 1'b1, 32'd1, 6'd2, 1'b1, 32'd1);
        bus.squash = 1'b1;
        cycle();
        check("squash_issue_valid", W'(bus.issue_valid), W'(0));
        check("squash_rs_full", W'(bus.rs_full), W'(0));
        cycle();

        // Asynchronous reset between edges with entries valid
        for (int i = 0; i < 2; i++) begin
            set_dis(3'b100, 32'h800, 32'h0, 5'(i), 6'd1, 1'b1, 32'd1, 6'd2, 1'b1, 32'd1);
            cycle();
        end
        check("pre_reset_valid", W'(bus.issue_valid), W'(1));
        #2 reset = 1'b0;
        #1;
        check("async_issue_valid", W'(bus.issue_valid), W'(0));
        check("async_rs_full", W'(bus.rs_full), W'(0));
        check("async_packet", W'(bus.rs_fu_packet), W'(0));
        mq.delete();
        exp_stall = 0;
        exp_full  = 0;
`ifdef RS_BRANCH_PERF_CNT_EN
        check("async_perf_stall", W'(perf_stall_cnt), W'(0));
`endif
        #1 reset = 1'b1;

        // One entry stalled for three cycles
        set_dis(3'b000, 32'h900, 32'h0, 5'd1, 6'd1, 1'b1, 32'd1, 6'd2, 1'b1, 32'd1);
        cycle();
        repeat (3) cycle();
`ifdef RS_BRANCH_PERF_CNT_EN
        check("perf_stall_3", W'(perf_stall_cnt), W'(3));
`endif
        bus.fu_ready = 1'b1;
        cycle();

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            bus.fu_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) < 6) begin
                set_dis(funcs[$urandom_range(0, 5)], $urandom, $urandom, ROB_LEN'($urandom),
                        PRF_LEN'($urandom_range(1, 7)), ($urandom_range(0, 2) != 0), $urandom,
                        PRF_LEN'($urandom_range(1, 7)), ($urandom_range(0, 2) != 0), $urandom);
            end
            if ($urandom_range(0, 1) == 1) set_cdb(PRF_LEN'($urandom_range(0, 7)), $urandom);
            bus.squash = ($urandom_range(0, 39) == 0);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rs_branch.md
Name: rs_branch

Overview:
- Reservation station for conditional-branch uops; sits between dispatch and the branch functional unit.
- Buffers dispatched branches and snoops the CDB to capture missing source operands.
- Issues the oldest operand-ready entry as an RS_FU_PACKET to the branch FU, where the condition is evaluated, using a valid/ready handshake.
- Flushes completely on squash.

Parameters:
- RS_SIZE, 4, number of entries (power of two, ≥2).
- PRF_LEN, 6, physical-register tag width.
- ROB_LEN, 5, ROB index width.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- dis_valid  in  1  dispatch request this cycle.
- dis_func  in  3  branch func3 (BEQ/BNE/BLT/BGE/BLTU/BGEU).
- dis_pc  in  XLEN  branch PC.
- dis_imm  in  XLEN  sign-extended offset.
- dis_rob_idx  in  ROB_LEN  owning ROB entry.
- dis_rs1_tag, dis_rs2_tag  in  PRF_LEN  source tags.
- dis_rs1_rdy, dis_rs2_rdy  in  1  operand already valid.
- dis_rs1_val, dis_rs2_val  in  XLEN  operand values (used when rdy=1).
- cdb_valid  in  1  CDB broadcast valid.
- cdb_tag  in  PRF_LEN  broadcast tag.
- cdb_value  in  XLEN  broadcast value.
- squash  in  1  flush all entries.
- fu_ready  in  1  branch FU accepts a packet.
- rs_full  out  1  no free entry; dispatch must not be asserted.
- issue_valid  out  1  rs_fu_packet holds a ready uop.
- rs_fu_packet  out  $bits(RS_FU_PACKET)  issued uop: func, pc, imm, rob_idx, rs1/rs2 values.

Behaviour:
- Reset: all entries invalid, age matrix cleared; rs_full=0, issue_valid=0, rs_fu_packet=0.
- Entry state (registered): valid; func; pc; imm; rob_idx; per operand {tag, rdy, val}; age-matrix row.
- Dispatch:
  - On an edge with dis_valid=1, squash=0 and rs_full=0, write the lowest-index free entry.
  - That entry becomes older-than-nothing and younger than all valid entries.
  - dis_valid while rs_full=1 is ignored (protocol error).
- Dispatch bypass: if cdb_valid and cdb_tag equals an un-ready dispatched tag in the same cycle, capture cdb_value and set rdy=1. Both operands may match.
- Wakeup: each valid entry with rdy=0 and a matching tag captures cdb_value and sets rdy=1 at the edge. The entry is issue-eligible the next cycle; there is no same-cycle CDB-to-issue path.
- Select: among valid entries with both operands rdy, choose the oldest via the age matrix.
  - issue_valid and rs_fu_packet are combinational from registered state only; there is no combinational path from any input.
- Handshake:
  - A transfer occurs on an edge where issue_valid=1 and fu_ready=1; the selected entry is invalidated at that edge.
  - If fu_ready=0, the same oldest-ready entry is held, unless an older entry becomes ready.
- rs_full: registered-state function, asserted when all RS_SIZE entries are valid. A slot freed by issue is reusable from the next cycle; there is no same-cycle free-and-refill.
- Squash:
  - Invalidates every entry at the edge and has priority over dispatch and issue in that cycle.
  - Any handshake completing in the squash cycle is treated as delivered; the FU discards it via its own squash.
- Reset mid-operation: all entries are dropped immediately (async), and outputs go to reset values without waiting for a clock.
- Tag 0 never appears un-ready; no special casing.

Optional Feature:
- Macro RS_BRANCH_PERF_CNT_EN.
- Defined: two extra outputs.
  - perf_stall_cnt (32): counts cycles with issue_valid=1 and fu_ready=0.
  - perf_full_cnt (32): counts cycles with rs_full=1.
  - Both reset to 0, wrap at 2^32, and are not cleared by squash.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Shared package:
  - RS_FU_PACKET typedef.
  - BR_FUNC enum: BEQ=000, BNE=001, BLT=100, BGE=101, BLTU=110, BGEU=111.
  - RS_BR_ENTRY struct.
  - XLEN constant.
- Sub-module rs_age_select: takes the age matrix and ready vector; produces a one-hot oldest-ready grant and an any-ready flag. Purely combinational, parameterised by RS_SIZE.

Test Plan:
- Reset, then dispatch BEQ with rs1=rs2=5, both rdy, fu_ready=1 → issue_valid the next cycle, packet func=000, values 5/5, rob_idx echoed; entry freed.
- Dispatch A (rs1 tag 7 not ready) then B (both ready) → B issues first. Then cdb tag 7 value 0x10 → A issues the following cycle with rs1_val=0x10.
- Four dispatches with fu_ready=0 → rs_full=1 and packet stable. Raise fu_ready → oldest issues first; rs_full drops the next cycle; a dispatch that cycle is accepted.
- Dispatch with rs2 tag 9 un-ready while cdb_valid, tag 9, value 0xFFFF_FFFF in the same cycle → entry stored rdy=1 and issues next cycle with rs2_val=0xFFFF_FFFF.
- Three valid entries, then squash together with dis_valid → all entries invalid, issue_valid=0, rs_full=0, dispatched uop dropped.
- Drop reset between clock edges with entries valid → outputs zero immediately. With RS_BRANCH_PERF_CNT_EN: 3 stalled cycles → perf_stall_cnt=3.
